unidade_busca: RTL and testbench

Instruction-fetch stage of the processor. Holds the program counter (PC), drives the byte address into the combinational instruction memory, and captures the returned word plus PC+4 into the IF/ID pipeline register. Handles stall, flush, taken-branch redirect, and out-of-range or misaligned fetch. It sits directly upstream of the instruction memory and feeds the decode stage.

---
 rtl/unidade_busca_pkg.sv | 17 +
 rtl/unidade_busca_if_id.sv | 61 ++++++
 rtl/unidade_busca.sv | 121 ++++++++++++
 tb/tb_unidade_busca.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/unidade_busca_pkg.sv
// pacote_busca: shared definitions for the instruction-fetch stage.
//   estado_busca_t : fetch FSM state (BUSCA = fetching, PARADO = stalled,
//                    ERRO = halted until reset)
//   NOP_PADRAO     : default bubble word placed into IF/ID
//   INCREMENTO_PC  : sequential PC step in bytes
package pacote_busca;

    typedef enum logic [1:0] {
        BUSCA  = 2'd0,
        PARADO = 2'd1,
        ERRO   = 2'd2
    } estado_busca_t;

    localparam logic [31:0] NOP_PADRAO    = 32'h0000_0000;
    localparam logic [31:0] INCREMENTO_PC = 32'd4;

endpackage

// File: rtl/unidade_busca_if_id.sv
// registrador_if_id: IF/ID pipeline register.
// Holds the fetched instruction, its PC+4 and a valid flag.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   carregar            : capture instrucao_in / pc_mais4_in as a real instruction
//   bolha               : insert a bubble (NOP, valido=0); wins over carregar
//   instrucao_in        : word from instruction memory
//   pc_mais4_in         : PC+4 of that word
//   instrucao, pc_mais4, valido : registered outputs to decode
// With neither carregar nor bolha the register holds (stall).
module registrador_if_id
    import pacote_busca::*;
#(
    parameter logic [31:0] NOP = NOP_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        carregar,
    input  logic        bolha,
    input  logic [31:0] instrucao_in,
    input  logic [31:0] pc_mais4_in,
    output logic [31:0] instrucao,
    output logic [31:0] pc_mais4,
    output logic        valido
);

    logic [31:0] instrucao_q, instrucao_d;
    logic [31:0] pc_mais4_q,  pc_mais4_d;
    logic        valido_q,    valido_d;

    always_comb begin
        instrucao_d = instrucao_q;
        pc_mais4_d  = pc_mais4_q;
        valido_d    = valido_q;
        if (bolha) begin
            // A bubble keeps the old PC+4; only the word and valid flag matter downstream.
            instrucao_d = NOP;
            valido_d    = 1'b0;
        end else if (carregar) begin
            instrucao_d = instrucao_in;
            pc_mais4_d  = pc_mais4_in;
            valido_d    = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instrucao_q <= NOP;
            pc_mais4_q  <= 32'h0;
            valido_q    <= 1'b0;
        end else begin
            instrucao_q <= instrucao_d;
            pc_mais4_q  <= pc_mais4_d;
            valido_q    <= valido_d;
        end
    end

    assign instrucao = instrucao_q;
    assign pc_mais4  = pc_mais4_q;
    assign valido    = valido_q;

endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: instruction-fetch stage.
// Holds the PC, drives it to the combinational instruction memory and
// captures the returned word plus PC+4 into the IF/ID register.
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   stall             : hold PC and IF/ID
//   flush             : next IF/ID capture becomes a bubble
//   desvio_tomado     : redirect PC to alvo_desvio (one bubble penalty)
//   alvo_desvio       : branch/jump target byte address
//   instrucao         : word returned by memory for endereco
//   endereco          : byte address to memory (= PC)
//   if_id_instrucao, if_id_pc_mais4, if_id_valido : IF/ID contents
//   erro              : sticky fetch error (PC out of range or misaligned target)
//   contador_busca    : saturating count of valid captures
module unidade_busca
    import pacote_busca::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 51,
    parameter logic [31:0] NOP       = NOP_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        desvio_tomado,
    input  logic [31:0] alvo_desvio,
    input  logic [31:0] instrucao,
    output logic [31:0] endereco,
    output logic [31:0] if_id_instrucao,
    output logic [31:0] if_id_pc_mais4,
    output logic        if_id_valido,
    output logic        erro,
    output logic [31:0] contador_busca
);

    localparam logic [29:0] LIMITE_PALAVRAS = 30'(MEM_WORDS);

    estado_busca_t estado_q, estado_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   contador_q, contador_d;
    logic [31:0]   pc_mais4;
    logic          fora_faixa;
    logic          alvo_desalinhado;
    logic          carregar;
    logic          bolha;

    assign pc_mais4         = pc_q + INCREMENTO_PC;
    assign fora_faixa       = (pc_q[31:2] >= LIMITE_PALAVRAS);
    // A misaligned target only matters when the redirect is actually taken.
    assign alvo_desalinhado = desvio_tomado && (alvo_desvio[1:0] != 2'b00);

    always_comb begin
        estado_d   = estado_q;
        pc_d       = pc_q;
        contador_d = contador_q;
        carregar   = 1'b0;
        bolha      = 1'b0;
        case (estado_q)
            ERRO: begin
                // Halted: everything frozen until reset.
            end
            default: begin
                if (fora_faixa || alvo_desalinhado) begin
                    estado_d = ERRO;
                    bolha    = 1'b1;
                end else if (desvio_tomado) begin
                    // Redirect beats stall: the wrong-path word is discarded.
                    pc_d     = alvo_desvio;
                    bolha    = 1'b1;
                    estado_d = BUSCA;
                end else if (flush) begin
                    if (!stall) begin
                        pc_d = pc_mais4;
                    end
                    bolha    = 1'b1;
                    estado_d = stall ? PARADO : BUSCA;
                end else if (stall) begin
                    estado_d = PARADO;
                end else begin
                    pc_d     = pc_mais4;
                    carregar = 1'b1;
                    estado_d = BUSCA;
                    if (contador_q != 32'hFFFF_FFFF) begin
                        contador_d = contador_q + 32'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= BUSCA;
            pc_q       <= RESET_PC;
            contador_q <= 32'h0;
        end else begin
            estado_q   <= estado_d;
            pc_q       <= pc_d;
            contador_q <= contador_d;
        end
    end

    registrador_if_id #(
        .NOP (NOP)
    ) u_if_id (
        .clock        (clock),
        .reset        (reset),
        .carregar     (carregar),
        .bolha        (bolha),
        .instrucao_in (instrucao),
        .pc_mais4_in  (pc_mais4),
        .instrucao    (if_id_instrucao),
        .pc_mais4     (if_id_pc_mais4),
        .valido       (if_id_valido)
    );

    assign endereco       = pc_q;
    assign erro           = (estado_q == ERRO);
    assign contador_busca = contador_q;

endmodule

// File: tb/tb_unidade_busca.sv
// Directed bench for unidade_busca. Memory word i holds 32'hA000_0000 + i,
// except word 0 which holds 32'h20080005. Inputs change and outputs are
// sampled on the falling edge.
module tb_unidade_busca;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        desvio_tomado;
    logic [31:0] alvo_desvio;
    logic [31:0] instrucao;
    logic [31:0] endereco;
    logic [31:0] if_id_instrucao;
    logic [31:0] if_id_pc_mais4;
    logic        if_id_valido;
    logic        erro;
    logic [31:0] contador_busca;

    logic [31:0] mem [0:63];
    int          total = 0;
    int          bad   = 0;

    always #5 clock = ~clock;

    always_comb begin
        if (endereco[31:8] == 24'h0) instrucao = mem[endereco[7:2]];
        else                         instrucao = 32'hDEAD_BEEF;
    end

    unidade_busca #(
        .RESET_PC  (32'h0),
        .MEM_WORDS (51),
        .NOP       (32'h0)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .desvio_tomado   (desvio_tomado),
        .alvo_desvio     (alvo_desvio),
        .instrucao       (instrucao),
        .endereco        (endereco),
        .if_id_instrucao (if_id_instrucao),
        .if_id_pc_mais4  (if_id_pc_mais4),
        .if_id_valido    (if_id_valido),
        .erro            (erro),
        .contador_busca  (contador_busca)
    );

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, esp);
        end
    endtask

    // Check the whole visible state in one call; one line per transaction.
    task automatic confere(input string tag, input logic [31:0] e_end, input logic [31:0] e_ins,
                           input logic [31:0] e_pc4, input logic e_val, input logic e_err,
                           input logic [31:0] e_cnt);
        verifica({tag, ".endereco"}, endereco, e_end);
        verifica({tag, ".instr"},    if_id_instrucao, e_ins);
        verifica({tag, ".pc4"},      if_id_pc_mais4, e_pc4);
        verifica({tag, ".valido"},   {31'h0, if_id_valido}, {31'h0, e_val});
        verifica({tag, ".erro"},     {31'h0, erro}, {31'h0, e_err});
        verifica({tag, ".cont"},     contador_busca, e_cnt);
        $display("txn %-12s end=%h ins=%h pc4=%h v=%b e=%b cnt=%0d",
                 tag, endereco, if_id_instrucao, if_id_pc_mais4, if_id_valido, erro, contador_busca);
    endtask

    task automatic passo(input logic s, input logic f, input logic d, input logic [31:0] a);
        stall = s; flush = f; desvio_tomado = d; alvo_desvio = a;
        @(posedge clock);
        @(negedge clock);
        stall = 1'b0; flush = 1'b0; desvio_tomado = 1'b0; alvo_desvio = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = 32'h2008_0005;

        reset = 1'b1; stall = 1'b0; flush = 1'b0; desvio_tomado = 1'b0; alvo_desvio = 32'h0;
        @(negedge clock);
        @(negedge clock);
        confere("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;

        passo(0, 0, 0, 32'h0);
        confere("first", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 1'b0, 32'd1);
        passo(0, 0, 0, 32'h0);
        confere("second", 32'h8, 32'hA000_0001, 32'h8, 1'b1, 1'b0, 32'd2);

        for (int k = 0; k < 3; k++) begin
            passo(1, 0, 0, 32'h0);
            confere("stall", 32'h8, 32'hA000_0001, 32'h8, 1'b1, 1'b0, 32'd2);
        end
        passo(0, 0, 0, 32'h0);
        confere("unstall", 32'hC, 32'hA000_0002, 32'hC, 1'b1, 1'b0, 32'd3);

        // Redirect wins over stall, then target arrives after one bubble.
        passo(1, 0, 1, 32'h14);
        confere("desvio", 32'h14, 32'h0, 32'hC, 1'b0, 1'b0, 32'd3);
        passo(0, 0, 0, 32'h0);
        confere("alvo", 32'h18, 32'hA000_0005, 32'h18, 1'b1, 1'b0, 32'd4);

        passo(0, 0, 1, 32'h10);
        confere("desvio10", 32'h10, 32'h0, 32'h18, 1'b0, 1'b0, 32'd4);
        passo(0, 1, 0, 32'h0);
        confere("flush", 32'h14, 32'h0, 32'h18, 1'b0, 1'b0, 32'd4);
        passo(0, 0, 0, 32'h0);
        confere("pos_flush", 32'h18, 32'hA000_0005, 32'h18, 1'b1, 1'b0, 32'd5);
        passo(1, 1, 0, 32'h0);
        confere("flush_stall", 32'h18, 32'h0, 32'h18, 1'b0, 1'b0, 32'd5);

        // Walk to the last valid word, then past the end.
        passo(0, 0, 1, 32'hC8);
        confere("para_c8", 32'hC8, 32'h0, 32'h18, 1'b0, 1'b0, 32'd5);
        passo(0, 0, 0, 32'h0);
        confere("ultima", 32'hCC, 32'hA000_0032, 32'hCC, 1'b1, 1'b0, 32'd6);
        passo(0, 0, 0, 32'h0);
        confere("fora", 32'hCC, 32'h0, 32'hCC, 1'b0, 1'b1, 32'd6);
        passo(0, 0, 1, 32'h0);
        confere("erro_ignora", 32'hCC, 32'h0, 32'hCC, 1'b0, 1'b1, 32'd6);

        // Asynchronous reset takes effect without a clock edge.
        reset = 1'b1;
        #1;
        confere("reset_erro", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        passo(0, 0, 0, 32'h0);
        confere("refetch", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 1'b0, 32'd1);
        passo(0, 0, 1, 32'h6);
        confere("desalinhado", 32'h4, 32'h0, 32'h4, 1'b0, 1'b1, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
